regfile_rtype_sequencer: RTL and testbench

Initiator-side controller for the three-port register file (two combinational read ports AR1/DR1 and AR2/DR2, one write port AW/DW/EnW).
- Accepts one R-type request at a time over a valid/ready handshake.
- Reads both source operands and computes the result.
- Writes the result back through the write port, then pulses done.
- Sits between the decode stage and Banco_registros in the multi-cycle datapath.

---
 rtl/regfile_rtype_sequencer_if.sv | 35 +++
 rtl/regfile_rtype_sequencer.sv | 133 +++++++++++++
 tb/tb_regfile_rtype_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_rtype_sequencer_if.sv
// Request handshake plus register-file port bundle between the decode stage,
// the R-type sequencer and the three-port register file.
interface regfile_rtype_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rs;
    logic [ADDR_W-1:0] req_rt;
    logic [ADDR_W-1:0] req_rd;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] AR1;
    logic [ADDR_W-1:0] AR2;
    logic [DATA_W-1:0] DR1;
    logic [DATA_W-1:0] DR2;
    logic [ADDR_W-1:0] AW;
    logic [DATA_W-1:0] DW;
    logic              EnW;
    logic [DATA_W-1:0] result;
    logic              done;
    logic              busy;

    // Sequencer side: drives the register file ports and the status outputs.
    modport master (
        input  req_valid, req_rs, req_rt, req_rd, req_op, DR1, DR2,
        output req_ready, AR1, AR2, AW, DW, EnW, result, done, busy
    );

    // Decode stage and register file side.
    modport slave (
        output req_valid, req_rs, req_rt, req_rd, req_op, DR1, DR2,
        input  req_ready, AR1, AR2, AW, DW, EnW, result, done, busy
    );
endinterface

// File: rtl/regfile_rtype_sequencer.sv
// Multi-cycle R-type sequencer: reads two operands from the register file,
// computes the result and writes it back, one request every five cycles.
module regfile_rtype_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    regfile_rtype_sequencer_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    state_t            r_state;
    logic [ADDR_W-1:0] r_rs;
    logic [ADDR_W-1:0] r_rt;
    logic [ADDR_W-1:0] r_rd;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_opA;
    logic [DATA_W-1:0] r_opB;
    logic [DATA_W-1:0] r_result;
    logic [ADDR_W-1:0] r_ar1;
    logic [ADDR_W-1:0] r_ar2;
    logic [ADDR_W-1:0] r_aw;
    logic [DATA_W-1:0] r_dw;
    logic              r_enw;
    logic              r_done;
    logic [DATA_W-1:0] w_alu;

    always_comb begin
        w_alu = r_result;
        case (r_op)
            OP_ADD:  w_alu = r_opA + r_opB;
            OP_SUB:  w_alu = r_opA - r_opB;
            OP_AND:  w_alu = r_opA & r_opB;
            OP_OR:   w_alu = r_opA | r_opB;
            OP_XOR:  w_alu = r_opA ^ r_opB;
            OP_SLT:  w_alu = ($signed(r_opA) < $signed(r_opB)) ? DATA_W'(1) : '0;
            OP_SLL:  w_alu = r_opA << r_opB[4:0];
            OP_NOP:  w_alu = r_result;
            default: w_alu = r_result;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_op     <= '0;
            r_opA    <= '0;
            r_opB    <= '0;
            r_result <= '0;
            r_ar1    <= '0;
            r_ar2    <= '0;
            r_aw     <= '0;
            r_dw     <= '0;
            r_enw    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_rs    <= bus.req_rs;
                        r_rt    <= bus.req_rt;
                        r_rd    <= bus.req_rd;
                        r_op    <= bus.req_op;
                        r_ar1   <= bus.req_rs;
                        r_ar2   <= bus.req_rt;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_opA   <= bus.DR1;
                    r_opB   <= bus.DR2;
                    r_state <= S_EXEC;
                end
                // Register 0 is hard-wired, and NOP must not disturb the destination.
                S_EXEC: begin
                    r_result <= w_alu;
                    r_aw     <= r_rd;
                    r_dw     <= w_alu;
                    r_enw    <= (r_rd != '0) && (r_op != OP_NOP);
                    r_state  <= S_WB;
                end
                S_WB: begin
                    r_aw    <= '0;
                    r_dw    <= '0;
                    r_enw   <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ar1   <= '0;
                    r_ar2   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Reset masks the registered outputs immediately so a write or done pulse in
    // flight is suppressed in the very cycle reset is asserted.
    assign bus.req_ready = rst_n && (r_state == S_IDLE);
    assign bus.busy      = rst_n && (r_state != S_IDLE);
    assign bus.EnW       = rst_n && r_enw;
    assign bus.done      = rst_n && r_done;
    assign bus.AR1       = rst_n ? r_ar1 : '0;
    assign bus.AR2       = rst_n ? r_ar2 : '0;
    assign bus.AW        = rst_n ? r_aw  : '0;
    assign bus.DW        = rst_n ? r_dw  : '0;
    assign bus.result    = r_result;

    logic w_unused;
    assign w_unused = ^{r_rs, r_rt};
endmodule

// File: tb/tb_regfile_rtype_sequencer.sv
// Directed bench for the R-type sequencer with a behavioural three-port
// register file; every expected value is hand computed.
module tb_regfile_rtype_sequencer;
    logic        clk;
    logic        rst_n;
    logic [31:0] rf [32];
    int          checks;
    int          errors;

    regfile_rtype_sequencer_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_rtype_sequencer #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.DR1 = rf[bus.AR1];
    assign bus.DR2 = rf[bus.AR2];

    always @(posedge clk) begin
        if (bus.EnW && (bus.AW != 5'd0)) rf[bus.AW] <= bus.DW;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full transaction from handshake to the return to IDLE.
    task automatic runOp(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [2:0] op,
                         input logic [31:0] expDw, input logic expEn);
        bus.req_rs    = rs;
        bus.req_rt    = rt;
        bus.req_rd    = rd;
        bus.req_op    = op;
        bus.req_valid = 1'b1;
        check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        tick;
        bus.req_valid = 1'b0;
        check({tag, ".ar1"}, 32'(bus.AR1), 32'(rs));
        check({tag, ".ar2"}, 32'(bus.AR2), 32'(rt));
        check({tag, ".busy"}, 32'(bus.busy), 32'd1);
        tick;
        check({tag, ".exec_enw"}, 32'(bus.EnW), 32'd0);
        tick;
        check({tag, ".wb_enw"}, 32'(bus.EnW), 32'(expEn));
        check({tag, ".wb_aw"}, 32'(bus.AW), 32'(rd));
        check({tag, ".wb_dw"}, bus.DW, expDw);
        check({tag, ".wb_done"}, 32'(bus.done), 32'd0);
        tick;
        check({tag, ".done"}, 32'(bus.done), 32'd1);
        check({tag, ".done_enw"}, 32'(bus.EnW), 32'd0);
        check({tag, ".done_aw"}, 32'(bus.AW), 32'd0);
        tick;
        check({tag, ".idle_done"}, 32'(bus.done), 32'd0);
        check({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, ".idle_ar1"}, 32'(bus.AR1), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_rs    = 5'd1;
        bus.req_rt    = 5'd2;
        bus.req_rd    = 5'd3;
        bus.req_op    = 3'b000;

        // Reset with a request pending
        tick;
        tick;
        check("rst.ready", 32'(bus.req_ready), 32'd0);
        check("rst.enw", 32'(bus.EnW), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.result", bus.result, 32'd0);
        rst_n         = 1'b1;
        bus.req_valid = 1'b0;
        tick;
        check("rst.ready_after", 32'(bus.req_ready), 32'd1);
        check("rst.busy_after", 32'(bus.busy), 32'd0);

        // ADD r1+r2 -> r3
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        runOp("add", 5'd1, 5'd2, 5'd3, 3'b000, 32'd12, 1'b1);
        check("add.r3", rf[3], 32'd12);
        check("add.result", bus.result, 32'd12);

        // SUB wrap, then signed SLT on the wrapped value
        rf[1] = 32'd0;
        rf[2] = 32'd1;
        runOp("sub", 5'd1, 5'd2, 5'd4, 3'b001, 32'hFFFF_FFFF, 1'b1);
        check("sub.r4", rf[4], 32'hFFFF_FFFF);
        runOp("slt", 5'd4, 5'd1, 5'd5, 3'b101, 32'd1, 1'b1);
        check("slt.r5", rf[5], 32'd1);

        // Logic ops, shift and rs==rt
        rf[10] = 32'hF0F0_00FF;
        rf[11] = 32'h0FF0_0F04;
        runOp("and", 5'd10, 5'd11, 5'd13, 3'b010, 32'h00F0_0004, 1'b1);
        runOp("or",  5'd10, 5'd11, 5'd14, 3'b011, 32'hFFF0_0FFF, 1'b1);
        runOp("xor", 5'd10, 5'd11, 5'd15, 3'b100, 32'hFF00_0FFB, 1'b1);
        runOp("sll", 5'd10, 5'd11, 5'd16, 3'b110, 32'h0F00_0FF0, 1'b1);
        runOp("same", 5'd10, 5'd10, 5'd12, 3'b000, 32'hE1E0_01FE, 1'b1);
        check("sll.r16", rf[16], 32'h0F00_0FF0);
        check("same.r12", rf[12], 32'hE1E0_01FE);

        // rd==rs uses the old value
        runOp("rdsrc", 5'd12, 5'd2, 5'd12, 3'b000, 32'hE1E0_01FF, 1'b1);
        check("rdsrc.r12", rf[12], 32'hE1E0_01FF);

        // Write to r0 is suppressed; NOP keeps the previous result
        runOp("r0", 5'd1, 5'd2, 5'd0, 3'b000, 32'd1, 1'b0);
        check("r0.r0", rf[0], 32'd0);
        rf[6] = 32'd99;
        runOp("nop", 5'd10, 5'd11, 5'd6, 3'b111, 32'd1, 1'b0);
        check("nop.r6", rf[6], 32'd99);
        check("nop.result", bus.result, 32'd1);

        // Back-to-back dependent requests with req_valid held high
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        rf[3] = 32'd0;
        bus.req_rs    = 5'd1;
        bus.req_rt    = 5'd2;
        bus.req_rd    = 5'd3;
        bus.req_op    = 3'b000;
        bus.req_valid = 1'b1;
        check("b2b.ready1", 32'(bus.req_ready), 32'd1);
        tick;
        bus.req_rs = 5'd3;
        bus.req_rt = 5'd3;
        bus.req_rd = 5'd8;
        check("b2b.ar1_first", 32'(bus.AR1), 32'd1);
        tick;
        tick;
        check("b2b.dw_first", bus.DW, 32'd12);
        check("b2b.aw_first", 32'(bus.AW), 32'd3);
        tick;
        check("b2b.done_first", 32'(bus.done), 32'd1);
        check("b2b.ready_in_done", 32'(bus.req_ready), 32'd0);
        tick;
        check("b2b.ready2", 32'(bus.req_ready), 32'd1);
        check("b2b.r3", rf[3], 32'd12);
        tick;
        bus.req_valid = 1'b0;
        check("b2b.ar1_second", 32'(bus.AR1), 32'd3);
        tick;
        tick;
        check("b2b.dw_second", bus.DW, 32'd24);
        check("b2b.aw_second", 32'(bus.AW), 32'd8);
        tick;
        check("b2b.done_second", 32'(bus.done), 32'd1);
        tick;
        check("b2b.r8", rf[8], 32'd24);

        // Reset asserted during EXEC aborts without writing
        rf[7] = 32'd55;
        bus.req_rs    = 5'd1;
        bus.req_rt    = 5'd2;
        bus.req_rd    = 5'd7;
        bus.req_op    = 3'b000;
        bus.req_valid = 1'b1;
        tick;
        bus.req_valid = 1'b0;
        tick;
        check("abort.exec_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        tick;
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.enw", 32'(bus.EnW), 32'd0);
        check("abort.done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        tick;
        check("abort.enw_after", 32'(bus.EnW), 32'd0);
        check("abort.done_after", 32'(bus.done), 32'd0);
        check("abort.ready", 32'(bus.req_ready), 32'd1);
        tick;
        check("abort.r7", rf[7], 32'd55);
        check("abort.result", bus.result, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
